pe_sort_feeder: RTL and testbench
=================================

PE_SORT_FEEDER -- requirements
Module: pe_sort_feeder

Interface
REQ-001 SHALL have parameter PAD_BYTE, default 8'h00, the byte value filling unused lanes of a short final vector.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the vector counter.
REQ-003 SHALL have port sys_clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port s_data  input  32  upstream beat carrying 4 bytes.
REQ-006 SHALL have port s_valid  input  1  s_data is valid.
REQ-007 SHALL have port s_last  input  1  this beat is the last beat of the job.
REQ-008 SHALL have port s_ready  output  1  the feeder accepts the beat this cycle.
REQ-009 SHALL have port sorter_clr  output  1  one-cycle clear pulse to pe_sort at job start.
REQ-010 SHALL have port sorter_en  output  1  one-cycle pulse to pe_sort: sorter_in is valid.
REQ-011 SHALL have port last_sort  output  1  qualifies sorter_en as the job's final vector.
REQ-012 SHALL have port sorter_in  output  256  packed 32-byte vector to pe_sort.
REQ-013 SHALL have port sorter_valid  input  1  pe_sort completion pulse for the last issued vector.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port vec_count  output  CNT_W  vectors issued in the current job; exists only under PE_SORT_FEEDER_STATS_EN.

Function
REQ-016 SHALL implement the FSM states IDLE, CLR, FILL, ISSUE and WAIT.
REQ-017 In IDLE, SHALL drive s_ready=0 and SHALL move to CLR on the first cycle s_valid=1.
REQ-018 In CLR, SHALL drive sorter_clr=1 and s_ready=0 for exactly one cycle, then move to FILL with beat_cnt=0.
REQ-019 In FILL, SHALL drive s_ready=1; a beat is accepted when s_valid&&s_ready.
REQ-020 Byte k of accepted beat b SHALL be written to sorter_in[(4*b+k)*8 +: 8] (b in 0..7, k in 0..3); beat 0 lands in bits 31:0.
REQ-021 On accepting beat 7, or any beat with s_last=1, SHALL move to ISSUE.
REQ-022 If s_last arrives on beat b<7, SHALL fill all bytes of beats b+1..7 with PAD_BYTE in that same cycle.
REQ-023 beat_cnt SHALL be 3 bits and SHALL wrap from 7 to 0 at the FILL-to-ISSUE transition.
REQ-024 In ISSUE, SHALL pulse sorter_en=1 for one cycle, with last_sort=1 iff the vector ended with s_last, then move to WAIT; s_ready=0.
REQ-025 sorter_in SHALL be registered and SHALL stay stable from ISSUE until the next FILL accepts its first beat.
REQ-026 In WAIT, SHALL hold s_ready=0 until sorter_valid=1, then go to IDLE if last_sort was set and to FILL otherwise.
REQ-027 SHALL ignore sorter_valid in every state other than WAIT.
REQ-028 SHALL never have two vectors outstanding: at most one sorter_en between consecutive accepted sorter_valid pulses.
REQ-029 sorter_clr, sorter_en and last_sort SHALL be registered outputs, glitch-free and mutually exclusive in time, except that last_sort is high with sorter_en.

Reset
REQ-030 While sys_rst_n=0, SHALL force state IDLE and all outputs to 0, including sorter_in, beat_cnt, the last flag and vec_count.
REQ-031 When reset is asserted mid-job, SHALL discard the partial vector; the next job SHALL begin with CLR.

Configuration
REQ-032 With PE_SORT_FEEDER_STATS_EN defined, SHALL clear vec_count in CLR, increment it in ISSUE, saturate it at all-ones and hold it after the job ends.
REQ-033 Without PE_SORT_FEEDER_STATS_EN, SHALL have no vec_count port and no counter logic.

Structure
REQ-034 Package pe_sort_pkg SHALL hold the FSM state enum and the constants SORT_VEC_W=256, SORT_BEAT_W=32 and SORT_BEATS=8.
REQ-035 SHALL be a single flat module with no sub-modules; the packing datapath is a lane-enable register bank.

Verification
REQ-036 Eight beats 32'h03020100, 32'h07060504 ... 32'h1f1e1d1c, last on beat 7 -> one sorter_clr pulse, then sorter_en with last_sort=1 and sorter_in=256'h1f1e...0100.
REQ-037 Three beats, last on beat 2, PAD_BYTE=8'hFF -> sorter_in[95:0] holds the data and sorter_in[255:96] are all 8'hFF bytes.
REQ-038 16 beats (2 vectors) with sorter_valid delayed 5 cycles after each sorter_en -> s_ready=0 throughout WAIT, the second sorter_en only after the first sorter_valid, last_sort only on the second, and vec_count=2 under the macro.
REQ-039 sorter_valid pulsed during IDLE and FILL -> no state change and no extra sorter_en.
REQ-040 sys_rst_n dropped after 4 beats, then a new 8-beat job -> all outputs 0 during reset, a fresh sorter_clr, and sorter_in contains only the new job's data.
REQ-041 s_valid toggling every other cycle during FILL -> beats are packed in order with no lane skipped and sorter_en fires once.

Source files
------------

// File: rtl/pe_sort_pkg.sv
// rtl/pe_sort_pkg.sv - FSM state encoding and vector geometry shared by pe_sort_feeder
package pe_sort_pkg;

  localparam int unsigned SORT_VEC_W      = 256;
  localparam int unsigned SORT_BEAT_W     = 32;
  localparam int unsigned SORT_BEATS      = 8;
  localparam int unsigned SORT_BEAT_IDX_W = $clog2(SORT_BEATS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FILL,
    ST_ISSUE,
    ST_WAIT
  } feeder_state_e;

endpackage

// File: rtl/pe_sort_feeder.sv
// rtl/pe_sort_feeder.sv - packs 4-byte beats into 32-byte vectors for pe_sort, one vector in flight
// Optional vec_count statistics port enabled by PE_SORT_FEEDER_STATS_EN.
module pe_sort_feeder
  import pe_sort_pkg::*;
#(
  parameter logic [7:0]  PAD_BYTE = 8'h00,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [SORT_BEAT_W-1:0] s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic                   sorter_clr,
  output logic                   sorter_en,
  output logic                   last_sort,
  output logic [SORT_VEC_W-1:0]  sorter_in,
  input  logic                   sorter_valid,
  output logic                   busy
`ifdef PE_SORT_FEEDER_STATS_EN
  ,
  output logic [CNT_W-1:0]       vec_count
`endif
);

  localparam logic [SORT_BEAT_W-1:0] PAD_WORD = {(SORT_BEAT_W / 8){PAD_BYTE}};
  localparam logic [SORT_BEAT_IDX_W-1:0] LAST_BEAT = SORT_BEAT_IDX_W'(SORT_BEATS - 1);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("pe_sort_feeder: CNT_W must be at least 1");
  end

  feeder_state_e              state;
  logic [SORT_BEAT_IDX_W-1:0] beat_cnt;
  logic                       last_flag;
  logic                       accept;
  logic [SORT_BEATS-1:0]      lane_wr;
  logic [SORT_BEATS-1:0]      lane_pad;

  assign accept = s_valid && s_ready;
  assign busy   = (state != ST_IDLE);

  // One data lane is loaded per beat; a short final beat pads every lane above it at once.
  always_comb begin
    lane_wr  = '0;
    lane_pad = '0;
    for (int i = 0; i < int'(SORT_BEATS); i++) begin
      lane_wr[i]  = accept && (beat_cnt == SORT_BEAT_IDX_W'(i));
      lane_pad[i] = accept && s_last && (SORT_BEAT_IDX_W'(i) > beat_cnt);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sorter_in <= '0;
    end else begin
      for (int i = 0; i < int'(SORT_BEATS); i++) begin
        if (lane_wr[i]) begin
          sorter_in[i*SORT_BEAT_W +: SORT_BEAT_W] <= s_data;
        end else if (lane_pad[i]) begin
          sorter_in[i*SORT_BEAT_W +: SORT_BEAT_W] <= PAD_WORD;
        end
      end
    end
  end

  // Pulse outputs are set on the transition into their state, so each is a clean flop output.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      beat_cnt   <= '0;
      last_flag  <= 1'b0;
      s_ready    <= 1'b0;
      sorter_clr <= 1'b0;
      sorter_en  <= 1'b0;
      last_sort  <= 1'b0;
    end else begin
      sorter_clr <= 1'b0;
      sorter_en  <= 1'b0;
      last_sort  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (s_valid) begin
            state      <= ST_CLR;
            sorter_clr <= 1'b1;
          end
        end
        ST_CLR: begin
          state    <= ST_FILL;
          beat_cnt <= '0;
          s_ready  <= 1'b1;
        end
        ST_FILL: begin
          if (accept) begin
            if (s_last || (beat_cnt == LAST_BEAT)) begin
              state     <= ST_ISSUE;
              beat_cnt  <= '0;
              s_ready   <= 1'b0;
              sorter_en <= 1'b1;
              last_sort <= s_last;
              last_flag <= s_last;
            end else begin
              beat_cnt <= beat_cnt + SORT_BEAT_IDX_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sorter_valid) begin
            if (last_flag) begin
              state     <= ST_IDLE;
              last_flag <= 1'b0;
            end else begin
              state    <= ST_FILL;
              beat_cnt <= '0;
              s_ready  <= 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef PE_SORT_FEEDER_STATS_EN
  // Saturating count of vectors issued since the last job start; holds once the job ends.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vec_count <= '0;
    end else if (state == ST_CLR) begin
      vec_count <= '0;
    end else if ((state == ST_ISSUE) && (vec_count != {CNT_W{1'b1}})) begin
      vec_count <= vec_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pe_sort_feeder.sv
// tb/tb_pe_sort_feeder.sv - directed self-checking bench for pe_sort_feeder
module tb_pe_sort_feeder;

  localparam logic [7:0] PAD   = 8'hFF;
  localparam int         CNT_W = 16;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic         sorter_clr;
  logic         sorter_en;
  logic         last_sort;
  logic [255:0] sorter_in;
  logic         sorter_valid;
  logic         busy;
  logic         sv_resp;
  logic         sv_spur;
`ifdef PE_SORT_FEEDER_STATS_EN
  logic [CNT_W-1:0] vec_count;
`endif

  assign sorter_valid = sv_resp | sv_spur;

  always #5 sys_clk = ~sys_clk;

  pe_sort_feeder #(.PAD_BYTE(PAD), .CNT_W(CNT_W)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .sorter_clr   (sorter_clr),
    .sorter_en    (sorter_en),
    .last_sort    (last_sort),
    .sorter_in    (sorter_in),
    .sorter_valid (sorter_valid),
    .busy         (busy)
`ifdef PE_SORT_FEEDER_STATS_EN
    ,
    .vec_count    (vec_count)
`endif
  );

  int total = 0;
  int bad   = 0;
  int clr_cnt = 0;
  int en_cnt  = 0;
  int resp_delay = 2;
  logic         outstanding = 1'b0;
  logic [255:0] cap_vec = '0;
  logic         cap_last = 1'b0;
  logic [255:0] exp_q[$];
  logic         exp_last_q[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: byte j of a job is seed+j; vectors are 8-beat slices, tail padded with PAD.
  function automatic logic [31:0] beat_word(input logic [7:0] seed, input int idx);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = seed + 8'(4*idx + k);
    return w;
  endfunction

  task automatic push_job(input logic [7:0] seed, input int n);
    int nv;
    logic [255:0] vec;
    nv = (n + 7) / 8;
    for (int v = 0; v < nv; v++) begin
      for (int l = 0; l < 8; l++)
        vec[l*32 +: 32] = (8*v + l < n) ? beat_word(seed, 8*v + l) : {4{PAD}};
      exp_q.push_back(vec);
      exp_last_q.push_back(v == nv - 1);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    int   t;
    logic acc;
    t = 0;
    s_data = d; s_valid = 1'b1; s_last = last;
    do begin
      @(negedge sys_clk); acc = s_ready;
      @(posedge sys_clk); #1; t++;
    end while (!acc && t < 300);
    if (!acc) chk("beat_accept_timeout", acc, 1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_job(input logic [7:0] seed, input int n, input int gap, input logic last);
    for (int b = 0; b < n; b++) begin
      send_beat(beat_word(seed, b), last && (b == n - 1));
      repeat (gap) begin @(posedge sys_clk); #1; end
    end
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    do begin @(negedge sys_clk); t++; end while (busy && t < 500);
    chk(nm, busy, 0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_sorter_in"}, sorter_in, 0);
    chk({nm, "_ctl"}, {s_ready, sorter_clr, sorter_en, last_sort, busy}, 0);
`ifdef PE_SORT_FEEDER_STATS_EN
    chk({nm, "_vec_count"}, vec_count, 0);
`endif
  endtask

  // Completion responder: one sorter_valid pulse resp_delay cycles after each sorter_en.
  initial begin
    sv_resp = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sorter_en && sys_rst_n) begin
        repeat (resp_delay) @(posedge sys_clk);
        #1 sv_resp = 1'b1;
        @(posedge sys_clk);
        #1 sv_resp = 1'b0;
      end
    end
  end

  always @(negedge sys_clk) begin
    logic [255:0] ev;
    logic         el;
    if (sys_rst_n) begin
      if (sorter_clr || sorter_en || last_sort)
        chk("pulse_excl", {sorter_clr && sorter_en, last_sort && !sorter_en}, 0);
      if (sorter_clr) clr_cnt++;
      if (outstanding) begin
        chk("wait_s_ready", s_ready, 0);
        chk("hold_sorter_in", sorter_in, cap_vec);
      end
      if (sorter_en) begin
        en_cnt++;
        chk("one_outstanding", outstanding, 0);
        if (exp_q.size() == 0) begin
          chk("spurious_en", exp_q.size(), 1);
        end else begin
          ev = exp_q.pop_front();
          el = exp_last_q.pop_front();
          chk("sorter_in", sorter_in, ev);
          chk("last_sort", last_sort, el);
        end
        cap_vec = sorter_in;
        cap_last = last_sort;
        outstanding = 1'b1;
      end else if (sorter_valid && outstanding) begin
        outstanding = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, e0;
    sys_rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; sv_spur = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_zero("reset");
    sys_rst_n = 1'b1;

    // Full 8-beat job, last on beat 7
    c0 = clr_cnt; e0 = en_cnt; resp_delay = 2;
    push_job(8'h00, 8);
    send_job(8'h00, 8, 0, 1'b1);
    wait_idle("t1_idle");
    chk("t1_clr", clr_cnt - c0, 1);
    chk("t1_en", en_cnt - e0, 1);
    chk("t1_vec_lit", cap_vec,
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
    chk("t1_last", cap_last, 1);

    // Three beats, padded tail
    e0 = en_cnt;
    push_job(8'h40, 3);
    send_job(8'h40, 3, 0, 1'b1);
    wait_idle("t2_idle");
    chk("t2_en", en_cnt - e0, 1);
    chk("t2_data_lit", cap_vec[95:0], 96'h4b4a4948_47464544_43424140);
    chk("t2_pad_lit", cap_vec[255:96], {20{8'hFF}});

    // Two vectors with slow completion
    c0 = clr_cnt; e0 = en_cnt; resp_delay = 5;
    push_job(8'h10, 16);
    send_job(8'h10, 16, 0, 1'b1);
    wait_idle("t3_idle");
    chk("t3_clr", clr_cnt - c0, 1);
    chk("t3_en", en_cnt - e0, 2);
    chk("t3_last", cap_last, 1);
`ifdef PE_SORT_FEEDER_STATS_EN
    chk("t3_vec_count", vec_count, 2);
`endif

    // Stray sorter_valid in IDLE, then in FILL with s_valid toggling
    e0 = en_cnt; resp_delay = 2;
    @(posedge sys_clk); #1 sv_spur = 1'b1;
    @(posedge sys_clk); #1 sv_spur = 1'b0;
    @(negedge sys_clk);
    chk("t4_idle_spur_busy", busy, 0);
    chk("t4_idle_spur_en", en_cnt - e0, 0);
    push_job(8'h60, 8);
    fork
      send_job(8'h60, 8, 1, 1'b1);
      begin
        repeat (6) @(posedge sys_clk);
        #1 sv_spur = 1'b1;
        @(posedge sys_clk);
        #1 sv_spur = 1'b0;
      end
    join
    wait_idle("t4_idle");
    chk("t4_en", en_cnt - e0, 1);

    // Reset mid-job, then a fresh job
    send_job(8'h80, 4, 0, 1'b0);
    @(posedge sys_clk); #1 sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check_zero("t5_in_reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    c0 = clr_cnt; e0 = en_cnt;
    push_job(8'hA0, 8);
    send_job(8'hA0, 8, 0, 1'b1);
    wait_idle("t5_idle");
    chk("t5_clr", clr_cnt - c0, 1);
    chk("t5_en", en_cnt - e0, 1);
    chk("t5_lane0_lit", cap_vec[31:0], 32'ha3a2a1a0);
    chk("t5_lane4_lit", cap_vec[159:128], 32'hb3b2b1b0);
`ifdef PE_SORT_FEEDER_STATS_EN
    chk("t5_vec_count", vec_count, 1);
`endif
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
